sm4_axis_host: RTL and testbench
================================

// Module: sm4_axis_host
// PURPOSE
//  Host-side initiator for the SM4 AXI4-Stream accelerator: takes one (key, block, direction) request,
//  serialises it as a 9-beat AXIS frame into the accelerator slave port, then collects the 4-beat result
//  frame from the accelerator master port and returns it as one 128-bit response. Sits between a
//  CPU/DMA request interface and the accelerator; one transaction in flight at a time.
// PARAMETERS
//  DATAWIDTH       32    AXIS TDATA width; only 32 is supported
//  TIMEOUT_CYCLES  1024  response watchdog limit in clk cycles; used only with SM4_HOST_TIMEOUT_EN
// PORTS
//  clk            in   1    single clock
//  rstn           in   1    asynchronous, active-low reset
//  req_valid      in   1    request valid
//  req_ready      out  1    request accepted when req_valid && req_ready
//  req_isdec      in   1    1 = decrypt, 0 = encrypt
//  req_key        in   128  master key, [127:96] sent first
//  req_data       in   128  input block, [127:96] sent first
//  rsp_valid      out  1    response valid, held until rsp_ready
//  rsp_ready      in   1    response consumer ready
//  rsp_data       out  128  result block, first received word in [127:96]
//  rsp_err        out  1    framing error or timeout, qualified by rsp_valid
//  busy           out  1    high in every state except IDLE
//  M_AXIS_TVALID/TDATA[31:0]/TSTRB[3:0]/TLAST out, M_AXIS_TREADY in: request frame to accelerator
//  S_AXIS_TVALID/TDATA[31:0]/TSTRB[3:0]/TLAST in, S_AXIS_TREADY out: result frame from accelerator
// BEHAVIOUR
//  - Reset values: req_ready=0 during reset, then 1 in IDLE. All other outputs reset to 0.
//  - States: IDLE -> SEND -> WAIT_RSP -> DONE -> IDLE.
//  - Request frame: beat0 header {31'b0, isdec}; beats1-4 key words, MSW first; beats5-8 data words,
//    MSW first. TSTRB is 4'hF on every beat. TLAST is set only on beat8.
//  - IDLE: req_ready=1. On accept, latch key, data and isdec, go to SEND. TVALID rises the next cycle.
//  - SEND: TVALID stays high. TDATA, TLAST and TSTRB stay stable until TREADY. A 4-bit beat counter
//    advances on each handshake. After the beat8 handshake, TVALID drops the same edge and the block
//    enters WAIT_RSP. With TREADY tied high, all 9 beats are sent in cycles 1..9 after accept.
//  - WAIT_RSP: S_AXIS_TREADY=1, and only in this state. Each accepted beat shifts into rsp_data
//    (shift left 32, new word in [31:0]). A 3-bit counter counts beats. S_AXIS_TSTRB is ignored.
//  - Normal end: beat 4 with TLAST=1 -> DONE, err=0.
//  - Early TLAST: TLAST on beat 1-3 -> DONE with err=1. rsp_data holds the partial shift.
//  - Missing TLAST on beat 4: set err=1 and keep rsp_data. Keep accepting and discarding beats until
//    TLAST, then go to DONE. The counter saturates and does not wrap.
//  - DONE: rsp_valid=1 from the cycle after the terminating beat. Hold rsp_data and rsp_err until
//    rsp_ready, then go to IDLE. req_ready is 1 from the cycle after that handshake; back-to-back
//    requests cost 1 idle cycle.
//  - req_valid outside IDLE is ignored and not latched.
//  - Reset mid-operation clears all state and abandons any partial frame. No TLAST is emitted for
//    the abandoned frame.
// CONFIGURATION
//  SM4_HOST_TIMEOUT_EN defined:
//   - A counter is cleared on entry to WAIT_RSP and on each accepted S beat, and increments otherwise.
//   - When it reaches TIMEOUT_CYCLES-1, go to DONE with rsp_err=1. Later S beats are not consumed
//     (TREADY=0 outside WAIT_RSP).
//  SM4_HOST_TIMEOUT_EN undefined: no counter; WAIT_RSP waits indefinitely. rsp_err reports framing
//   errors only.
// STRUCTURE
//  - Package sm4_host_pkg holds:
//     - the state enum {IDLE, SEND, WAIT_RSP, DONE};
//     - REQ_BEATS=9, RSP_BEATS=4, HDR_ISDEC_BIT=0.
//  - Sub-module sm4_host_deser holds the S-side 32->128 shift register, beat counter and TLAST checks.
//    Its outputs are done and err pulses.
//  - The top holds the FSM, request latch, M-side mux and the optional watchdog.
// TESTING
//  1. Encrypt request, key=0123456789abcdeffedcba9876543210, data = same, TREADY=1:
//     - M beats are 00000000,01234567,89abcdef,fedcba98,76543210 then the data words; TLAST on beat 8.
//     - Return 681edf34,d206965e,86b3e94f,536e4246 -> rsp_data=681edf34d206965e86b3e94f536e4246, err=0.
//  2. Decrypt (isdec=1) with random M_AXIS_TREADY stalls -> header word 00000001.
//     - TDATA and TLAST stay stable while stalled; exactly 9 handshakes.
//  3. Result with TLAST on beat 2 -> rsp_valid with err=1.
//     - Result with no TLAST until beat 6 -> err=1 after beat 6; rsp_data = beats 1-4.
//  4. Hold rsp_ready=0 for 20 cycles -> rsp_valid, rsp_data and err stay stable, req_ready=0.
//     - A req_valid pulse in that window is ignored.
//  5. Assert rstn=0 during beat 4 of SEND -> all outputs 0 asynchronously.
//     - After release, a new request produces a clean 9-beat frame.
//  6. (SM4_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=16) no S beats -> rsp_valid, err=1 at 16 cycles after
//     entering WAIT_RSP.

Source files
------------

// File: rtl/sm4_host_pkg.sv
// Shared types and constants for the SM4 AXI4-Stream host initiator.
package sm4_host_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } host_state_e;

  localparam int unsigned REQ_BEATS     = 9;
  localparam int unsigned RSP_BEATS     = 4;
  localparam int unsigned HDR_ISDEC_BIT = 0;

  // Request frame word for a given beat: header, key MSW-first, data MSW-first.
  function automatic logic [31:0] req_word(input logic [3:0] beat, input logic isdec,
                                           input logic [127:0] key, input logic [127:0] data);
    logic [31:0] w;
    w = '0;
    case (beat)
      4'd0: w[HDR_ISDEC_BIT] = isdec;
      4'd1: w = key[127:96];
      4'd2: w = key[95:64];
      4'd3: w = key[63:32];
      4'd4: w = key[31:0];
      4'd5: w = data[127:96];
      4'd6: w = data[95:64];
      4'd7: w = data[63:32];
      4'd8: w = data[31:0];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sm4_host_deser.sv
// Result-frame deserialiser: shifts 32-bit beats into a 128-bit word and flags framing errors.
module sm4_host_deser
  import sm4_host_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         s_valid,
  input  logic         s_ready,
  input  logic         s_last,
  input  logic [31:0]  s_data,
  output logic [127:0] data,
  output logic         done,
  output logic         err
);

  logic [2:0] beat_cnt;
  logic       hs;

  assign hs   = s_valid && s_ready;
  assign done = hs && s_last;
  // A well-formed frame ends exactly on its fourth beat; anything else is a framing error.
  assign err  = done && (beat_cnt != 3'(RSP_BEATS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
      data     <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      data     <= '0;
    end else if (hs) begin
      if (beat_cnt < 3'(RSP_BEATS)) data <= {data[95:0], s_data};
      if (beat_cnt != 3'd7) beat_cnt <= beat_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/sm4_axis_host.sv
// Host initiator for the SM4 AXIS accelerator: 9-beat request out, 4-beat result in.
// Optional response watchdog enabled by defining SM4_HOST_TIMEOUT_EN.
// Handshakes: a transfer happens on a rising edge where valid && ready; a source holds valid and
// payload stable until that edge, and never waits on ready before raising valid.
module sm4_axis_host
  import sm4_host_pkg::*;
#(
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_isdec,
  input  logic [127:0]           req_key,
  input  logic [127:0]           req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   M_AXIS_TVALID,
  output logic [DATAWIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATAWIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                   M_AXIS_TLAST,
  input  logic                   M_AXIS_TREADY,
  input  logic                   S_AXIS_TVALID,
  input  logic [DATAWIDTH-1:0]   S_AXIS_TDATA,
  input  logic [DATAWIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                   S_AXIS_TLAST,
  output logic                   S_AXIS_TREADY,
  output logic [1:0]             dbg_state
);

  host_state_e  state, next_state;
  logic         rdy_en;
  logic         isdec_q;
  logic [127:0] key_q, data_q;
  logic [3:0]   beat_q;
  logic         err_q;
  logic         accept, m_hs, last_beat, enter_wait;
  logic         deser_done, deser_err, timeout;
  logic         unused_ok;

  assign accept     = req_valid && req_ready;
  assign m_hs       = M_AXIS_TVALID && M_AXIS_TREADY;
  assign last_beat  = (beat_q == 4'(REQ_BEATS - 1));
  assign enter_wait = (state == SEND) && m_hs && last_beat;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = SEND;
      SEND:     if (enter_wait) next_state = WAIT_RSP;
      WAIT_RSP: if (deser_done || timeout) next_state = DONE;
      DONE:     if (rsp_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // rdy_en keeps req_ready low until the first edge after reset release.
  always_comb begin
    req_ready     = 1'b0;
    M_AXIS_TVALID = 1'b0;
    S_AXIS_TREADY = 1'b0;
    rsp_valid     = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        req_ready = rdy_en;
        busy      = 1'b0;
      end
      SEND:     M_AXIS_TVALID = 1'b1;
      WAIT_RSP: S_AXIS_TREADY = 1'b1;
      DONE:     rsp_valid     = 1'b1;
      default:  busy          = 1'b1;
    endcase
  end

  assign M_AXIS_TDATA = M_AXIS_TVALID ? req_word(beat_q, isdec_q, key_q, data_q) : '0;
  assign M_AXIS_TSTRB = {(DATAWIDTH/8){M_AXIS_TVALID}};
  assign M_AXIS_TLAST = M_AXIS_TVALID && last_beat;
  assign rsp_err      = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en  <= 1'b0;
      isdec_q <= 1'b0;
      key_q   <= '0;
      data_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        isdec_q <= req_isdec;
        key_q   <= req_key;
        data_q  <= req_data;
        beat_q  <= '0;
        err_q   <= 1'b0;
      end else if ((state == SEND) && m_hs && !last_beat) begin
        beat_q <= beat_q + 4'd1;
      end
      if (state == WAIT_RSP) begin
        if (deser_done)   err_q <= deser_err;
        else if (timeout) err_q <= 1'b1;
      end
    end
  end

  sm4_host_deser u_deser (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (enter_wait),
    .s_valid (S_AXIS_TVALID),
    .s_ready (S_AXIS_TREADY),
    .s_last  (S_AXIS_TLAST),
    .s_data  (S_AXIS_TDATA),
    .data    (rsp_data),
    .done    (deser_done),
    .err     (deser_err)
  );

`ifdef SM4_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wd_cnt <= '0;
    else if (enter_wait || (S_AXIS_TVALID && S_AXIS_TREADY)) wd_cnt <= '0;
    else if (state == WAIT_RSP) wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout   = (state == WAIT_RSP) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign unused_ok = ^S_AXIS_TSTRB;
`else
  assign timeout   = 1'b0;
  assign unused_ok = ^{S_AXIS_TSTRB, (TIMEOUT_CYCLES > 0)};
`endif

endmodule

// File: tb/tb_sm4_axis_host.sv
// Directed bench for sm4_axis_host: request framing, result framing errors, back-pressure, reset.
module tb_sm4_axis_host;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         req_valid = 1'b0, req_isdec = 1'b0;
  logic         req_ready;
  logic [127:0] req_key = '0, req_data = '0;
  logic         rsp_valid, rsp_err, busy;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         m_tvalid, m_tlast;
  logic         m_tready = 1'b1;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tstrb;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [31:0]  s_tdata = '0;
  logic [3:0]   s_tstrb = '0;
  logic         s_tready;
  logic [1:0]   dbg_state;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  localparam logic [127:0] K1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] R1 = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] D2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] R2 = 128'hdeadbeefcafef00d123456789abcdef0;

  sm4_axis_host #(.DATAWIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_isdec(req_isdec),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb),
    .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks; all driving and sampling happens on the falling edge
  task automatic send_req(input logic isdec, input logic [127:0] key, input logic [127:0] data);
    int n;
    req_isdec = isdec; req_key = key; req_data = data; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_idle", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("req_ready_busy", req_ready, 1'b0);
    exp_q.delete();
    exp_q.push_back({31'b0, isdec});
    for (int i = 3; i >= 0; i--) exp_q.push_back(key[i*32 +: 32]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(data[i*32 +: 32]);
  endtask

  task automatic collect_m(input bit stall, input int nbeats);
    int hs, cyc;
    logic prev_stall;
    logic [31:0] pd, e;
    logic pl;
    hs = 0; cyc = 0; prev_stall = 1'b0; pd = '0; pl = 1'b0;
    chk("m_tvalid_first", m_tvalid, 1'b1);
    while (hs < nbeats && cyc < 300) begin
      if (prev_stall) begin
        chk("m_tdata_stable", m_tdata, pd);
        chk("m_tlast_stable", m_tlast, pl);
      end
      m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        chk("m_tdata", m_tdata, e);
        chk("m_tlast", m_tlast, (hs == 8));
        chk("m_tstrb", m_tstrb, 4'hF);
        hs++;
      end
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
      @(negedge clk);
      cyc++;
    end
    chk("m_beat_count", hs, nbeats);
    if (hs == 9) begin
      chk("m_tvalid_after_frame", m_tvalid, 1'b0);
      chk("s_tready_wait", s_tready, 1'b1);
    end
    m_tready = 1'b1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l; s_tstrb = 4'($urandom_range(0, 15));
    n = 0;
    while (!s_tready && n < 50) begin @(negedge clk); n++; end
    chk("s_tready", s_tready, 1'b1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_rsp(input logic [127:0] r);
    for (int i = 3; i >= 0; i--) send_beat(r[i*32 +: 32], (i == 0));
  endtask

  // scoreboard check of the response, then the consumer handshake
  task automatic check_rsp(input logic [127:0] d, input logic e);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_data", rsp_data, d);
    chk("rsp_err", rsp_err, e);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 1'b0);
    chk("busy_after_hs", busy, 1'b0);
    chk("req_ready_after_hs", req_ready, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"},
        {m_tvalid, m_tdata, m_tstrb, m_tlast, s_tready, rsp_valid, rsp_err, busy, req_ready, dbg_state},
        '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
  endtask

  initial begin
    // reset state
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("req_ready_out_of_reset", req_ready, 1'b1);

    // 1: encrypt, known vector, no stalls
    send_req(1'b0, K1, K1);
    collect_m(1'b0, 9);
    send_rsp(R1);
    check_rsp(R1, 1'b0);

    // 2: decrypt with random stalls on the request stream
    @(negedge clk);
    send_req(1'b1, K2, D2);
    collect_m(1'b1, 9);
    send_rsp(R2);
    check_rsp(R2, 1'b0);

    // 3a: TLAST on beat 2
    send_req(1'b0, K2, K1);
    collect_m(1'b0, 9);
    send_beat(32'h11111111, 1'b0);
    send_beat(32'h22222222, 1'b1);
    check_rsp({64'b0, 32'h11111111, 32'h22222222}, 1'b1);

    // 3b: TLAST only on beat 6; the result keeps beats 1-4
    send_req(1'b1, K1, D2);
    collect_m(1'b0, 9);
    send_beat(32'ha0a0a0a1, 1'b0);
    send_beat(32'ha0a0a0a2, 1'b0);
    send_beat(32'ha0a0a0a3, 1'b0);
    send_beat(32'ha0a0a0a4, 1'b0);
    chk("no_rsp_after_beat4", rsp_valid, 1'b0);
    send_beat(32'ha0a0a0a5, 1'b0);
    chk("no_rsp_after_beat5", rsp_valid, 1'b0);
    chk("s_tready_beat6", s_tready, 1'b1);
    send_beat(32'ha0a0a0a6, 1'b1);
    check_rsp(128'ha0a0a0a1a0a0a0a2a0a0a0a3a0a0a0a4, 1'b1);

    // 4: consumer holds off for 20 cycles; a stray request is ignored
    send_req(1'b0, K1, K1);
    collect_m(1'b0, 9);
    send_rsp(R1);
    for (int i = 0; i < 20; i++) begin
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_data", rsp_data, R1);
      chk("hold_rsp_err", rsp_err, 1'b0);
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_state_done", dbg_state, 2'd3);
      req_valid = (i == 5);
      req_isdec = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_rsp(R1, 1'b0);
    @(negedge clk);
    chk("stray_req_ignored_busy", busy, 1'b0);
    chk("stray_req_ignored_tvalid", m_tvalid, 1'b0);

    // 5: reset while beat 4 of the request is on the bus
    send_req(1'b0, K2, D2);
    collect_m(1'b0, 4);
    chk("mid_frame_beat4", m_tdata, K2[31:0]);
    #2 rstn = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("req_ready_after_mid_reset", req_ready, 1'b1);
    send_req(1'b1, K1, K1);
    collect_m(1'b0, 9);
    send_rsp(R2);
    check_rsp(R2, 1'b0);

`ifdef SM4_HOST_TIMEOUT_EN
    // 6: no result beats; watchdog ends the wait 16 cycles after entering WAIT_RSP
    send_req(1'b0, K1, K2);
    collect_m(1'b0, 9);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("timeout_not_yet", rsp_valid, 1'b0);
    end
    @(negedge clk);
    chk("timeout_s_tready", s_tready, 1'b0);
    check_rsp('0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global time bound in case a wait loop misbehaves
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
